trip_debounce_latch: RTL and testbench
======================================

// Module: trip_debounce_latch
// PURPOSE
//  Downstream of the per-channel sensor-trip comparators and mode qualification in the
//  instrumentation path. Per channel, it debounces the raw sensor trip over consecutive
//  sample strobes, applies the channel mode (bypass/operate/manual) and holds the
//  resulting trip until an operator reset. trip_out is the latched vector the voting
//  stage consumes.
// PARAMETERS
//  NChannels      3  number of instrumentation channels
//  DebounceCount  3  consecutive tripped samples required to latch (>=1)
//  CntW (local)   $clog2(DebounceCount+1)  per-channel counter width
// PORTS
//  clk           in   1            system clock; all state on rising edge
//  rst           in   1            asynchronous, active-high reset
//  sample_valid  in   1            strobe: sensor_trips/mode valid this cycle
//  sensor_trips  in   NChannels    raw comparator result, bit ch = channel ch
//  mode          in   2*NChannels  channel ch mode = mode[2*ch+1 -: 2]; 0 bypass, 1 operate, 2 manual
//  reset_trip    in   NChannels    operator reset request per channel, sampled every cycle
//  trip_out      out  NChannels    latched trip per channel (registered)
//  trip_new      out  NChannels    1-cycle pulse: channel latch went 0->1 this update
//  trip_any_new  out  1            OR-reduction of trip_new (registered with it)
// BEHAVIOUR
//  Reset (async assert, sync release): cnt[ch]=0, trip_out=0, trip_new=0, trip_any_new=0.
//  State per channel: cnt[ch] (saturating 0..DebounceCount) and latch[ch] (= trip_out[ch]).
//  set[ch] for a sample_valid cycle, by mode:
//   0 bypass : cnt <= 0; set=0; latch holds its value (bypass does not clear a trip)
//   1 operate: sensor_trips[ch]=1 -> cnt <= min(cnt+1, DebounceCount);
//              set=1 iff the new cnt == DebounceCount
//              sensor_trips[ch]=0 -> cnt <= 0; set=0 (any gap restarts the count)
//   2 manual : cnt <= DebounceCount; set=1 immediately
//   3 (illegal): treated as manual (fail-safe trip)
//  No sample_valid: cnt holds; set=0.
//  Latch update each cycle: set -> latch<=1; else reset_trip[ch] -> latch<=0 and cnt<=0;
//   else hold. set beats reset in the same cycle (latch stays 1; cnt follows the set rule).
//  Latency: trip_out reflects the sample in the cycle after the sample_valid edge (1 clk).
//  trip_new[ch] = 1 for exactly one cycle, coincident with trip_out[ch] rising. A latch
//   that is already set and set again gives no pulse. It is 0 in every other cycle.
//  Channels are fully independent; no cross-channel state.
//  sensor_trips, mode and reset_trip are treated as synchronous to clk; no CDC inside.
//  rst asserted mid-debounce clears all counts and latches at once. After release,
//   the full DebounceCount samples are needed again.
// TESTING (NChannels=3, DebounceCount=3)
//  1 ch0 mode=1, sensor_trips[0]=1 on 3 consecutive strobes -> trip_out[0]=1 the cycle
//    after the 3rd strobe, trip_new=3'b001 for 1 cycle, trip_any_new=1; trip_out=0 after 2 strobes.
//  2 ch1 mode=1, pattern 1,1,0,1,1 over 5 strobes -> trip_out[1] stays 0; a 6th strobe
//    with 1 -> trip_out[1]=1.
//  3 ch2 mode=2, one strobe with sensor_trips=0 -> trip_out[2]=1 next cycle; mode=0 for
//    that channel -> strobe gives no set and trip_out[2] stays 1 until reset_trip[2]=1,
//    then 0 next cycle.
//  4 ch0 latched, mode=1, sensor=1: strobe with reset_trip[0]=1 in the same cycle ->
//    trip_out[0] stays 1, no trip_new pulse. Reset without strobe -> trip_out[0]=0,
//    then 3 strobes are needed to re-latch.
//  5 mode=3 on ch1 -> behaves as manual: trip_out[1]=1 one cycle after the strobe.
//  6 2 of 3 strobes counted on ch0, assert rst asynchronously mid-cycle -> all outputs 0
//    immediately; after release, 2 strobes do not trip and the 3rd does.

Source files
------------

// File: rtl/trip_debounce_latch.sv
// Per-channel sensor trip debouncer with mode qualification and an operator-cleared latch.
// trip_out is the latched vector the voting stage consumes; trip_new pulses on each 0->1 latch.
module trip_debounce_latch #(
    parameter int NChannels     = 3,
    parameter int DebounceCount = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   sample_valid,
    input  logic [NChannels-1:0]   sensor_trips,
    input  logic [2*NChannels-1:0] mode,
    input  logic [NChannels-1:0]   reset_trip,
    output logic [NChannels-1:0]   trip_out,
    output logic [NChannels-1:0]   trip_new,
    output logic                   trip_any_new
);

    localparam int CntW = $clog2(DebounceCount + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(DebounceCount);

    typedef enum logic [1:0] {
        MODE_BYPASS  = 2'd0,
        MODE_OPERATE = 2'd1,
        MODE_MANUAL  = 2'd2,
        MODE_ILLEGAL = 2'd3
    } mode_e;

    function automatic logic [CntW-1:0] sat_inc(input logic [CntW-1:0] c);
        if (c >= CntMax) begin
            return CntMax;
        end
        return c + CntW'(1);
    endfunction

    logic [NChannels-1:0][CntW-1:0] cnt_p1;
    logic [NChannels-1:0][CntW-1:0] cnt_nxt;
    logic [NChannels-1:0]           latch_p1;
    logic [NChannels-1:0]           latch_nxt;
    logic [NChannels-1:0]           set_v;
    logic [NChannels-1:0]           new_v;

    always_comb begin
        cnt_nxt   = cnt_p1;
        latch_nxt = latch_p1;
        set_v     = '0;
        for (int ch = 0; ch < NChannels; ch++) begin
            if (sample_valid) begin
                case (mode_e'(mode[2*ch+1 -: 2]))
                    MODE_BYPASS: begin
                        cnt_nxt[ch] = '0;
                    end
                    MODE_OPERATE: begin
                        if (sensor_trips[ch]) begin
                            cnt_nxt[ch] = sat_inc(cnt_p1[ch]);
                            set_v[ch]   = (sat_inc(cnt_p1[ch]) == CntMax);
                        end else begin
                            cnt_nxt[ch] = '0;
                        end
                    end
                    // Manual and the illegal encoding both force a trip (fail-safe).
                    default: begin
                        cnt_nxt[ch] = CntMax;
                        set_v[ch]   = 1'b1;
                    end
                endcase
            end
            // A set in the same cycle overrides the operator reset.
            if (set_v[ch]) begin
                latch_nxt[ch] = 1'b1;
            end else if (reset_trip[ch]) begin
                latch_nxt[ch] = 1'b0;
                cnt_nxt[ch]   = '0;
            end
        end
        new_v = latch_nxt & ~latch_p1;
    end

    // ---- stage p1: debounce counters, latches and edge pulses ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_p1       <= '0;
            latch_p1     <= '0;
            trip_new     <= '0;
            trip_any_new <= 1'b0;
        end else begin
            cnt_p1       <= cnt_nxt;
            latch_p1     <= latch_nxt;
            trip_new     <= new_v;
            trip_any_new <= |new_v;
        end
    end

    assign trip_out = latch_p1;

endmodule

// File: tb/tb_trip_debounce_latch.sv
// Directed bench for trip_debounce_latch (3 channels, debounce of 3 strobes).
// Each step drives inputs for one clock and checks registered outputs 1 ns after the edge.
module tb_trip_debounce_latch;

    logic       clk = 1'b0;
    logic       rst;
    logic       sample_valid;
    logic [2:0] sensor_trips;
    logic [5:0] mode;
    logic [2:0] reset_trip;
    logic [2:0] trip_out;
    logic [2:0] trip_new;
    logic       trip_any_new;

    int total = 0;
    int bad   = 0;

    trip_debounce_latch #(.NChannels(3), .DebounceCount(3)) dut (
        .clk          (clk),
        .rst          (rst),
        .sample_valid (sample_valid),
        .sensor_trips (sensor_trips),
        .mode         (mode),
        .reset_trip   (reset_trip),
        .trip_out     (trip_out),
        .trip_new     (trip_new),
        .trip_any_new (trip_any_new)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic sv, input logic [2:0] sens, input logic [5:0] md,
                        input logic [2:0] rt);
        sample_valid = sv;
        sensor_trips = sens;
        mode         = md;
        reset_trip   = rt;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [2:0] to, input logic [2:0] tn);
        chk({tag, ".trip_out"}, {5'd0, trip_out}, {5'd0, to});
        chk({tag, ".trip_new"}, {5'd0, trip_new}, {5'd0, tn});
        chk({tag, ".any_new"}, {7'd0, trip_any_new}, {7'd0, |tn});
    endtask

    initial begin
        rst = 1'b1;
        sample_valid = 1'b0;
        sensor_trips = '0;
        mode = '0;
        reset_trip = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk_out("reset", 3'b000, 3'b000);
        rst = 1'b0;

        // 1: ch0 operate, three consecutive tripped strobes
        step(1, 3'b001, 6'b000001, 3'b000); chk_out("t1.s1", 3'b000, 3'b000);
        step(1, 3'b001, 6'b000001, 3'b000); chk_out("t1.s2", 3'b000, 3'b000);
        step(1, 3'b001, 6'b000001, 3'b000); chk_out("t1.s3", 3'b001, 3'b001);
        step(0, 3'b000, 6'b000001, 3'b000); chk_out("t1.hold", 3'b001, 3'b000);
        step(0, 3'b000, 6'b000001, 3'b001); chk_out("t1.clr", 3'b000, 3'b000);

        // 2: ch1 operate, a gap restarts the count
        step(1, 3'b010, 6'b000100, 3'b000);
        step(1, 3'b010, 6'b000100, 3'b000);
        step(1, 3'b000, 6'b000100, 3'b000); chk_out("t2.gap", 3'b000, 3'b000);
        step(1, 3'b010, 6'b000100, 3'b000);
        step(1, 3'b010, 6'b000100, 3'b000); chk_out("t2.s5", 3'b000, 3'b000);
        step(1, 3'b010, 6'b000100, 3'b000); chk_out("t2.s6", 3'b010, 3'b010);
        step(0, 3'b000, 6'b000100, 3'b010); chk_out("t2.clr", 3'b000, 3'b000);

        // 3: ch2 manual trips at once; bypass keeps the latch until operator reset
        step(1, 3'b000, 6'b100000, 3'b000); chk_out("t3.man", 3'b100, 3'b100);
        step(1, 3'b100, 6'b000000, 3'b000); chk_out("t3.byp", 3'b100, 3'b000);
        step(0, 3'b000, 6'b000000, 3'b000); chk_out("t3.idle", 3'b100, 3'b000);
        step(0, 3'b000, 6'b000000, 3'b100); chk_out("t3.clr", 3'b000, 3'b000);

        // 4: set beats reset; a plain reset clears the count as well
        step(1, 3'b001, 6'b000001, 3'b000);
        step(1, 3'b001, 6'b000001, 3'b000);
        step(1, 3'b001, 6'b000001, 3'b000); chk_out("t4.lat", 3'b001, 3'b001);
        step(1, 3'b001, 6'b000001, 3'b001); chk_out("t4.setrst", 3'b001, 3'b000);
        step(0, 3'b000, 6'b000001, 3'b001); chk_out("t4.rst", 3'b000, 3'b000);
        step(1, 3'b001, 6'b000001, 3'b000); chk_out("t4.r1", 3'b000, 3'b000);
        step(1, 3'b001, 6'b000001, 3'b000); chk_out("t4.r2", 3'b000, 3'b000);
        step(1, 3'b001, 6'b000001, 3'b000); chk_out("t4.r3", 3'b001, 3'b001);
        step(0, 3'b000, 6'b000001, 3'b001); chk_out("t4.clr", 3'b000, 3'b000);

        // 5: illegal mode on ch1 acts as manual
        step(1, 3'b000, 6'b001100, 3'b000); chk_out("t5.ill", 3'b010, 3'b010);
        step(0, 3'b000, 6'b000000, 3'b010); chk_out("t5.clr", 3'b000, 3'b000);

        // 6: async reset mid-debounce, with ch2 latched beforehand
        step(1, 3'b000, 6'b100000, 3'b000); chk_out("t6.pre", 3'b100, 3'b100);
        step(1, 3'b001, 6'b000001, 3'b000);
        step(1, 3'b001, 6'b000001, 3'b000); chk_out("t6.two", 3'b100, 3'b000);
        #3;
        rst = 1'b1;
        #1;
        chk_out("t6.async", 3'b000, 3'b000);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(1, 3'b001, 6'b000001, 3'b000); chk_out("t6.a1", 3'b000, 3'b000);
        step(1, 3'b001, 6'b000001, 3'b000); chk_out("t6.a2", 3'b000, 3'b000);
        step(1, 3'b001, 6'b000001, 3'b000); chk_out("t6.a3", 3'b001, 3'b001);
        step(0, 3'b000, 6'b000001, 3'b000); chk_out("t6.end", 3'b001, 3'b000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
